ln_job_sequencer: RTL and testbench

LN_JOB_SEQUENCER -- requirements
Module: ln_job_sequencer

---
 rtl/ln_job_sequencer.sv | 102 ++++++++++
 tb/tb_ln_job_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ln_job_sequencer.sv
// ln_job_sequencer: queues x operands and runs them one at a time through an ln(x+1) core,
// with a per-job timeout and a single-entry result register toward downstream.
module ln_job_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [15:0] inX,
  output logic        inReady,
  output logic        coreStart,
  output logic [15:0] coreX,
  input  logic        coreDone,
  input  logic [17:0] coreResult,
  output logic        outValid,
  output logic [17:0] outResult,
  output logic        outErr,
  input  logic        outReady,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_RELEASE} state_t;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  state_t        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [17:0]   res_q, res_d;
  logic          push, pop, load, load_err, free, active;
  assign active    = state_q == S_WAIT || state_q == S_HOLD;
  assign inReady   = cnt_q != (AW+1)'(FIFO_DEPTH);
  assign push      = inValid && inReady;
  assign free      = !valid_q || outReady;
  assign coreStart = active;
  assign coreX     = active ? mem_q[rd_q] : '0;
  assign outValid  = valid_q;
  assign outResult = res_q;
  assign outErr    = err_q;
  assign busy      = state_q != S_IDLE || cnt_q != '0;
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    pop      = 1'b0;
    load     = 1'b0;
    load_err = 1'b0;
    case (state_q)
      S_IDLE: if (cnt_q != '0) begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: if (coreDone) begin
        load    = free;
        pop     = free;
        state_d = free ? S_RELEASE : S_HOLD;
      end else if (tmo_q == CW'(TIMEOUT - 1)) begin
        // counter saturates here until the result register can take the error word
        load     = free;
        load_err = free;
        pop      = free;
        state_d  = free ? S_RELEASE : S_WAIT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      S_HOLD: if (free) begin
        load    = 1'b1;
        pop     = 1'b1;
        state_d = S_RELEASE;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = load || (valid_q && !outReady);
    res_d   = load ? (load_err ? 18'h3FFFF : coreResult) : res_q;
    err_d   = load ? load_err : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= inX;
  end
endmodule

// File: tb/tb_ln_job_sequencer.sv
// tb_ln_job_sequencer: directed vector table plus hand-written corner sequences, with a
// behavioural core whose result is x<<2 after a programmable number of start cycles.
module tb_ln_job_sequencer;
  logic        clk = 1'b0;
  logic        rst, inValid, inReady, coreStart, coreDone, outValid, outErr, outReady, busy;
  logic [15:0] inX, coreX;
  logic [17:0] coreResult, outResult;
  int          lat, ccnt, total, passed;
  bit          never_done;
  logic [17:0] got[$];

  typedef struct {
    logic [15:0] x;
    int          lat;
    logic [17:0] exp_res;
    logic        exp_err;
  } vec_t;
  vec_t vecs[6];

  ln_job_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inX(inX), .inReady(inReady),
    .coreStart(coreStart), .coreX(coreX), .coreDone(coreDone), .coreResult(coreResult),
    .outValid(outValid), .outResult(outResult), .outErr(outErr), .outReady(outReady),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !coreStart) begin
      ccnt     <= 0;
      coreDone <= 1'b0;
    end else begin
      ccnt <= ccnt + 1;
      if (!never_done && ccnt >= lat - 1) begin
        coreDone   <= 1'b1;
        coreResult <= {coreX, 2'b00};
      end
    end
  end

  always @(negedge clk)
    if (!rst && outValid && outReady) got.push_back(outResult);

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic push(input logic [15:0] x);
    bit rdy;
    bit ok = 0;
    inValid = 1'b1;
    inX     = x;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk) rdy = inReady;
      @(posedge clk) #1;
      if (rdy) begin
        ok = 1;
        break;
      end
    end
    inValid = 1'b0;
    if (!ok) chk("push_accept", 0, 1);
  endtask

  task automatic wait_ov(input int max, output int n);
    n = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (outValid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, cs;
    vecs[0] = '{16'h0000, 3, 18'h00000, 1'b0};
    vecs[1] = '{16'h1234, 1, 18'h048D0, 1'b0};
    vecs[2] = '{16'hFFFF, 10, 18'h3FFFC, 1'b0};
    vecs[3] = '{16'h8000, 63, 18'h20000, 1'b0};
    vecs[4] = '{16'h0001, 64, 18'h3FFFF, 1'b1};
    vecs[5] = '{16'hABCD, 5, 18'h2AF34, 1'b0};
    total = 0; passed = 0;
    rst = 1'b1; inValid = 1'b0; inX = '0; outReady = 1'b1;
    lat = 3; never_done = 0; coreResult = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_inReady", inReady, 1);
    chk("rst_coreStart", coreStart, 0);
    chk("rst_coreX", coreX, 0);
    chk("rst_outValid", outValid, 0);
    chk("rst_outResult", outResult, 0);
    chk("rst_outErr", outErr, 0);
    chk("rst_busy", busy, 0);

    // accepting edge A: IDLE->WAIT at A+1, coreStart visible from then on
    @(posedge clk) #1;
    lat = 4;
    push(16'h0420);
    @(negedge clk);
    chk("lat_start_low", coreStart, 0);
    @(negedge clk);
    chk("lat_start_high", coreStart, 1);
    chk("lat_coreX", coreX, 16'h0420);
    wait_ov(100, n);
    chk("lat_res", outResult, 18'h01080);
    repeat (3) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      push(vecs[i].x);
      wait_ov(200, n);
      chk($sformatf("vec%0d_seen", i), n >= 0, 1);
      chk($sformatf("vec%0d_res", i), outResult, vecs[i].exp_res);
      chk($sformatf("vec%0d_err", i), outErr, vecs[i].exp_err);
      repeat (3) @(posedge clk);
      #1;
    end

    never_done = 1;
    push(16'h7777);
    cs = 0;
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (outValid) begin
        n = i;
        break;
      end
      if (coreStart) cs++;
    end
    chk("tmo_seen", n >= 0, 1);
    chk("tmo_wait_cycles", cs, 64);
    chk("tmo_res", outResult, 18'h3FFFF);
    chk("tmo_err", outErr, 1);
    @(negedge clk);
    chk("tmo_busy", busy, 0);
    chk("tmo_inReady", inReady, 1);
    never_done = 0;
    @(posedge clk) #1;

    // result register occupied while the next job completes -> HOLD, then load+drain together
    got.delete();
    outReady = 1'b0;
    lat = 3;
    push(16'h0100);
    wait_ov(100, n);
    chk("hold_first", outResult, 18'h00400);
    @(posedge clk) #1;
    push(16'h0200);
    repeat (20) @(negedge clk);
    chk("hold_start", coreStart, 1);
    chk("hold_keep_res", outResult, 18'h00400);
    chk("hold_keep_valid", outValid, 1);
    @(posedge clk) #1 outReady = 1'b1;
    @(negedge clk);
    chk("hold_pre_res", outResult, 18'h00400);
    @(negedge clk);
    chk("ld_dr_valid", outValid, 1);
    chk("ld_dr_res", outResult, 18'h00800);
    chk("ld_dr_err", outErr, 0);
    chk("release_start", coreStart, 0);
    @(negedge clk);
    chk("drained_valid", outValid, 0);
    chk("idle_start", coreStart, 0);
    chk("ld_dr_count", got.size(), 2);
    @(posedge clk) #1;

    got.delete();
    lat = 8;
    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    push(16'h4444);
    @(negedge clk);
    chk("full_inReady", inReady, 0);
    @(posedge clk) #1;
    push(16'h5555);
    for (int i = 0; i < 1000 && got.size() < 5; i++) @(negedge clk);
    chk("b2b_count", got.size(), 5);
    if (got.size() == 5) begin
      chk("b2b_0", got[0], 18'h04444);
      chk("b2b_1", got[1], 18'h08888);
      chk("b2b_2", got[2], 18'h0CCCC);
      chk("b2b_3", got[3], 18'h11110);
      chk("b2b_4", got[4], 18'h15554);
    end
    repeat (3) @(posedge clk);
    #1;

    lat = 30;
    push(16'h0A0A);
    push(16'h0B0B);
    push(16'h0C0C);
    got.delete();
    repeat (3) @(negedge clk);
    chk("mid_in_wait", coreStart, 1);
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_start", coreStart, 0);
    chk("mid_rst_inReady", inReady, 1);
    chk("mid_rst_valid", outValid, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (100) @(negedge clk);
    chk("mid_rst_no_out", got.size(), 0);
    chk("mid_rst_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
